// File: rtl/key_debounce_latch8.sv
// Eight-line key front end: 2-flop sync, per-line debounce, press latch and
// priority one-hot offer with valid/ack handshake toward the priority encoder.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | nothing offered; picks highest pending press next cycle
// S_OFFER | req holds a frozen one-hot press, waiting for ack
module key_debounce_latch8 #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] raw,
    input  logic       ack,
    input  logic       clr,
    output logic [7:0] req,
    output logic       valid,
    output logic [7:0] level,
    output logic [7:0] pend,
    output logic       dropped
);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES - 1);

    state_t           state, state_nx;
    logic [7:0]       s1, s2;
    logic [CNT_W-1:0] cnt    [8];
    logic [CNT_W-1:0] cnt_nx [8];
    logic [7:0]       level_nx, rise, sel, take;
    logic [7:0]       pend_nx, req_nx;
    logic             valid_nx, dropped_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '0;
            s2    <= '0;
            level <= '0;
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            level <= level_nx;
            for (int i = 0; i < 8; i++) cnt[i] <= cnt_nx[i];
        end
    end

    // Counter restarts whenever the line agrees with its debounced level.
    always_comb begin
        level_nx = level;
        for (int i = 0; i < 8; i++) begin
            cnt_nx[i] = '0;
            if (s2[i] != level[i]) begin
                if (cnt[i] == CNT_TC) level_nx[i] = s2[i];
                else                  cnt_nx[i]   = cnt[i] + 1'b1;
            end
        end
    end

    assign rise = level_nx & ~level;

    always_comb begin
        sel = '0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i]) sel = 8'(1) << i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            req     <= '0;
            valid   <= 1'b0;
            pend    <= '0;
            dropped <= 1'b0;
        end else begin
            state   <= state_nx;
            req     <= req_nx;
            valid   <= valid_nx;
            pend    <= pend_nx;
            dropped <= dropped_nx;
        end
    end

    // A press on the key being acked merges into the fresh bit, not a drop.
    always_comb begin
        state_nx = state;
        req_nx   = req;
        valid_nx = valid;
        take     = '0;
        case (state)
            S_IDLE: begin
                if (pend != '0) begin
                    req_nx   = sel;
                    valid_nx = 1'b1;
                    state_nx = S_OFFER;
                end
            end
            S_OFFER: begin
                if (ack) begin
                    take     = req;
                    req_nx   = '0;
                    valid_nx = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        pend_nx    = (pend & ~take) | rise;
        dropped_nx = dropped | (|(rise & pend & ~take));
        if (clr) begin
            state_nx   = S_IDLE;
            req_nx     = '0;
            valid_nx   = 1'b0;
            pend_nx    = '0;
            dropped_nx = 1'b0;
        end
    end

endmodule
